handshake_fifo: RTL and testbench



---
 rtl/handshake_pkg.sv | 20 ++
 rtl/handshake_fifo_mem.sv | 36 +++
 rtl/handshake_fifo.sv | 74 +++++++
 tb/tb_handshake_fifo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/handshake_pkg.sv
// Shared definitions for valid/ready handshaking blocks and channel buffers.
package handshake_pkg;

  localparam int unsigned HS_DATA_WIDTH = 8;
  localparam int unsigned HS_FIFO_DEPTH = 4;

  // Pointer width for a power-of-two depth, at least 1 bit.
  function automatic int unsigned hs_ptr_width(input int unsigned depth);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < depth) begin
      w = w + 1;
    end
    if (w == 0) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write with reset clear, asynchronous read.
module handshake_fifo_mem
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HS_DATA_WIDTH,
  parameter int unsigned DEPTH      = HS_FIFO_DEPTH,
  parameter int unsigned ADDR_W     = hs_ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage: cleared on reset, otherwise written at the write address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head-of-queue read straight from the registers.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/handshake_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy reporting.
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HS_DATA_WIDTH,
  parameter int unsigned DEPTH      = HS_FIFO_DEPTH,
  parameter int unsigned ADDR_W     = hs_ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  // Flags and handshakes come only from registered occupancy, never from m_ready.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    s_ready = !rst && !full;
    m_valid = !empty;
    push    = s_valid && s_ready;
    pop     = m_valid && m_ready;
  end

  // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ADDR_W'(wr_ptr + 1'b1);
      end
      if (pop) begin
        rd_ptr <= ADDR_W'(rd_ptr + 1'b1);
      end
      if (push && !pop) begin
        count <= CNT_W'(count + 1'b1);
      end else if (pop && !push) begin
        count <= CNT_W'(count - 1'b1);
      end
    end
  end

  handshake_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (s_data),
    .raddr (rd_ptr),
    .rdata (m_data)
  );

endmodule

// File: tb/tb_handshake_fifo.sv
// Randomized and directed bench for handshake_fifo against a queue-based reference model.
module tb_handshake_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int n_checks;
  int n_fail;

  logic [DW-1:0] q[$];
  bit            mem_clean;
  int            delivered;

  handshake_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model at the edge.
  task automatic cycle(input logic r, input logic sv, input logic [DW-1:0] sd, input logic mr);
    bit do_push;
    bit do_pop;
    rst     = r;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    #1;
    check("s_ready", 32'(s_ready), 32'(!r && (q.size() < DEPTH)));
    check("count",   32'(count),   32'(q.size()));
    check("m_valid", 32'(m_valid), 32'(q.size() > 0));
    check("empty",   32'(empty),   32'(q.size() == 0));
    check("full",    32'(full),    32'(q.size() == DEPTH));
    if (q.size() > 0) begin
      check("m_data", 32'(m_data), 32'(q[0]));
    end else if (mem_clean) begin
      check("m_data_reset", 32'(m_data), 32'h0);
    end
    do_push = sv && !r && (q.size() < DEPTH);
    do_pop  = mr && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      mem_clean = 1'b1;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        delivered++;
      end
      if (do_push) begin
        q.push_back(sd);
        mem_clean = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] fill_vals [4];
    n_checks  = 0;
    n_fail    = 0;
    mem_clean = 1'b0;
    delivered = 0;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;
    fill_vals[0] = 8'h5A;
    fill_vals[1] = 8'hA5;
    fill_vals[2] = 8'h00;
    fill_vals[3] = 8'hFF;
    @(negedge clk);

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      #1;
      check("s_ready_in_reset", 32'(s_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
    end
    q.delete();
    mem_clean = 1'b1;
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Single word in and out.
    cycle(1'b0, 1'b1, 8'h5A, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Fill to full, then a held fifth word is refused.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, fill_vals[i], 1'b0);
    end
    cycle(1'b0, 1'b1, 8'h11, 1'b0);
    cycle(1'b0, 1'b1, 8'h11, 1'b0);

    // Drain with the fifth word still held; it enters once full drops.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, (q.size() < 5) && !(q.size() > 0 && q[q.size()-1] == 8'h11), 8'h11, 1'b1);
    end
    check("held_word_accepted", 32'(q.size() > 0 ? q[q.size()-1] : 8'h00), 32'h11);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
    end

    // Streaming 16 words through with both sides always ready.
    delivered = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b1);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("stream_delivered", 32'(delivered), 32'd16);

    // Reset mid-operation discards three buffered words.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    end
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    cycle(1'b0, 1'b1, 8'hC3, 1'b0);
    check("first_after_reset", 32'(m_data), 32'hC3);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
            8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
